// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and constants for the wishbone memory-port arbiter.
// Optional retry handling is enabled by defining WB_ARB_RETRY_EN.
package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } wbarb_state_t;

    localparam int LINE_BYTES = 16;
    localparam int OFF_W      = $clog2(LINE_BYTES);

    function automatic int rr_next(input int g, input int n);
        return (g + 1 == n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Single-beat wishbone bus between the arbiter (master) and the
// unified cache (slave).
interface wb_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    localparam int OW = $clog2(LINE_W / 8);

    logic [ADDR_W-OW-1:0] wb_adr;
    logic [LINE_W-1:0]    wb_dat_m;
    logic [LINE_W-1:0]    wb_dat_s;
    logic [LINE_W/8-1:0]  wb_sel;
    logic                 wb_we;
    logic                 wb_stb;
    logic                 wb_cyc;
    logic                 wb_ack;
    logic                 wb_rty;

    modport master (
        output wb_adr, wb_dat_m, wb_sel,
        output wb_we, wb_stb, wb_cyc,
        input  wb_dat_s, wb_ack, wb_rty
    );

    modport slave (
        input  wb_adr, wb_dat_m, wb_sel,
        input  wb_we, wb_stb, wb_cyc,
        output wb_dat_s, wb_ack, wb_rty
    );

endinterface

// File: rtl/wb_mem_arbiter_lane_sel.sv
// Maps a word-aligned line offset and byte enables onto line byte lanes.
// Reads select the whole word; writes select only the enabled bytes.
module wb_mem_arbiter_lane_sel #(
    parameter int OW   = 4,
    parameter int BE_W = 2,
    parameter int LN_W = 3
) (
    input  logic [OW-1:0]        off_i,
    input  logic [BE_W-1:0]      ben_i,
    input  logic                 we_i,
    output logic [(1<<OW)-1:0]   sel_o,
    output logic [LN_W-1:0]      lane_o
);
    localparam int NB   = 1 << OW;
    localparam int WB_W = OW - LN_W;

    logic [NB-1:0] mask;
    logic          unused_ok;

    assign lane_o = off_i[OW-1:WB_W];
    assign mask   = NB'(we_i ? ben_i : {BE_W{1'b1}});
    assign sel_o  = mask << (int'(lane_o) * BE_W);

    assign unused_ok = ^off_i[WB_W-1:0];

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter merging NUM_CH word ports onto one line-wide
// wishbone master. WB_ARB_RETRY_EN enables bounded wb_rty reissue.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int WORD_W  = 16,
    parameter int LINE_W  = 128,
    parameter int MAX_RTY = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*WORD_W-1:0]   ch_wdata,
    input  logic [NUM_CH*WORD_W/8-1:0] ch_ben,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic [WORD_W-1:0]          ch_rdata,
    output logic                       ch_err,
    wb_mem_arbiter_if.master           wb
);
    localparam int BE_W  = WORD_W / 8;
    localparam int OW    = $clog2(LINE_W / 8);
    localparam int LN_W  = OW - $clog2(BE_W);
    localparam int LANES = LINE_W / WORD_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    wbarb_state_t          state_q, state_d;
    logic [CH_W-1:0]       rr_q, rr_d;
    logic [CH_W-1:0]       g_q, g_d;
    logic [ADDR_W-OW-1:0]  adr_q, adr_d;
    logic [LINE_W-1:0]     dat_q, dat_d;
    logic [LINE_W/8-1:0]   sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  stb_q, stb_d;
    logic [LN_W-1:0]       lane_q, lane_d;
    logic [NUM_CH-1:0]     resp_q, resp_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;

    logic                  gnt_vld;
    logic [CH_W-1:0]       gnt;
    int                    gi;
    logic [ADDR_W-1:0]     m_addr;
    logic [WORD_W-1:0]     m_wdata;
    logic [BE_W-1:0]       m_ben;
    logic                  m_we;
    logic [LINE_W/8-1:0]   m_sel;
    logic [LN_W-1:0]       m_lane;
    logic [WORD_W-1:0]     lane_word;

`ifdef WB_ARB_RETRY_EN
    localparam int RTY_W = (MAX_RTY > 0) ? $clog2(MAX_RTY + 1) : 1;
    logic [RTY_W-1:0]      rty_q, rty_d;
    logic                  err_q, err_d;
`else
    logic                  unused_ok;
    assign unused_ok = wb.wb_rty ^ 1'(MAX_RTY);
`endif

    // First requester at or after the rr pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_vld && ch_req[(int'(rr_q) + i) % NUM_CH]) begin
                gnt_vld = 1'b1;
                gnt     = CH_W'((int'(rr_q) + i) % NUM_CH);
            end
        end
    end

    assign gi      = int'(gnt);
    assign m_addr  = ch_addr[gi*ADDR_W +: ADDR_W];
    assign m_wdata = ch_wdata[gi*WORD_W +: WORD_W];
    assign m_ben   = ch_ben[gi*BE_W +: BE_W];
    assign m_we    = ch_we[gi];

    wb_mem_arbiter_lane_sel #(
        .OW   (OW),
        .BE_W (BE_W),
        .LN_W (LN_W)
    ) u_lane_sel (
        .off_i  (m_addr[OW-1:0]),
        .ben_i  (m_ben),
        .we_i   (m_we),
        .sel_o  (m_sel),
        .lane_o (m_lane)
    );

    assign lane_word = wb.wb_dat_s[int'(lane_q)*WORD_W +: WORD_W];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        stb_d   = stb_q;
        lane_d  = lane_q;
        resp_d  = '0;
        rdata_d = '0;
`ifdef WB_ARB_RETRY_EN
        rty_d   = rty_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    g_d    = gnt;
                    rr_d   = CH_W'(rr_next(gi, NUM_CH));
                    adr_d  = m_addr[ADDR_W-1:OW];
                    dat_d  = {LANES{m_wdata}};
                    sel_d  = m_sel;
                    we_d   = m_we;
                    lane_d = m_lane;
`ifdef WB_ARB_RETRY_EN
                    rty_d  = '0;
`endif
                    // Empty write completes without touching the bus.
                    if (m_we && m_ben == '0) begin
                        state_d     = RESP;
                        resp_d[gnt] = 1'b1;
                    end else begin
                        state_d = BUS;
                        stb_d   = 1'b1;
                    end
                end
            end
            BUS: begin
`ifdef WB_ARB_RETRY_EN
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (wb.wb_ack) begin
                    state_d      = RESP;
                    stb_d        = 1'b0;
                    resp_d[g_q]  = 1'b1;
                    rdata_d      = lane_word;
                end else if (wb.wb_rty) begin
                    stb_d = 1'b0;
                    if (rty_q == RTY_W'(MAX_RTY)) begin
                        state_d     = RESP;
                        resp_d[g_q] = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        rty_d = rty_q + 1'b1;
                    end
                end
`else
                if (wb.wb_ack) begin
                    state_d     = RESP;
                    stb_d       = 1'b0;
                    resp_d[g_q] = 1'b1;
                    rdata_d     = lane_word;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            g_q     <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            lane_q  <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
`ifdef WB_ARB_RETRY_EN
            rty_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            lane_q  <= lane_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
`ifdef WB_ARB_RETRY_EN
            rty_q   <= rty_d;
            err_q   <= err_d;
`endif
        end
    end

    assign wb.wb_adr   = adr_q;
    assign wb.wb_dat_m = dat_q;
    assign wb.wb_sel   = sel_q;
    assign wb.wb_we    = we_q & stb_q;
    assign wb.wb_stb   = stb_q;
    assign wb.wb_cyc   = stb_q;
    assign ch_resp     = resp_q;
    assign ch_rdata    = rdata_q;
`ifdef WB_ARB_RETRY_EN
    assign ch_err      = err_q;
`else
    assign ch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: vector table plus hand-written
// sequences for reset, arbitration, stalls and retry corner cases.
module tb_wb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   ch_req = '0;
    logic [1:0]   ch_we = '0;
    logic [31:0]  ch_addr = '0;
    logic [31:0]  ch_wdata = '0;
    logic [3:0]   ch_ben = '0;
    logic [1:0]   ch_resp;
    logic [15:0]  ch_rdata;
    logic         ch_err;

    int n_chk = 0;
    int n_err = 0;

    wb_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) wbi ();

    wb_mem_arbiter #(
        .NUM_CH(2), .ADDR_W(16), .WORD_W(16), .LINE_W(128), .MAX_RTY(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_ben   (ch_ben),
        .ch_resp  (ch_resp),
        .ch_rdata (ch_rdata),
        .ch_err   (ch_err),
        .wb       (wbi)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ch;
        logic         we;
        logic [15:0]  addr;
        logic [15:0]  wdata;
        logic [1:0]   ben;
        logic [127:0] line;
        int           dly;
        logic [11:0]  exp_adr;
        logic [15:0]  exp_sel;
        logic [15:0]  exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch_req = '0;
        ch_we = '0;
        ch_addr = '0;
        ch_wdata = '0;
        ch_ben = '0;
        wbi.wb_ack = 1'b0;
        wbi.wb_rty = 1'b0;
        wbi.wb_dat_s = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] oh;
        oh = 2'(1 << v.ch);
        ch_req = oh;
        ch_we = v.we ? oh : 2'b00;
        ch_addr = 32'(v.addr) << (16 * v.ch);
        ch_wdata = 32'(v.wdata) << (16 * v.ch);
        ch_ben = 4'(v.ben) << (2 * v.ch);
        tick();
        chk("v_stb", wbi.wb_stb, 1'b1);
        chk("v_cyc", wbi.wb_cyc, 1'b1);
        chk("v_adr", wbi.wb_adr, v.exp_adr);
        chk("v_sel", wbi.wb_sel, v.exp_sel);
        chk("v_we", wbi.wb_we, v.we);
        chk("v_dat_m", wbi.wb_dat_m, {8{v.wdata}});
        for (int d = 0; d < v.dly; d++) begin
            tick();
            chk("hold_stb", wbi.wb_stb, 1'b1);
            chk("hold_adr", wbi.wb_adr, v.exp_adr);
            chk("hold_sel", wbi.wb_sel, v.exp_sel);
            chk("hold_dat_m", wbi.wb_dat_m, {8{v.wdata}});
            chk("hold_resp", ch_resp, 2'b00);
        end
        wbi.wb_dat_s = v.line;
        wbi.wb_ack = 1'b1;
        tick();
        wbi.wb_ack = 1'b0;
        ch_req = '0;
        chk("v_resp", ch_resp, oh);
        chk("v_rdata", ch_rdata, v.exp_rdata);
        chk("v_err", ch_err, 1'b0);
        chk("v_stb_drop", wbi.wb_stb, 1'b0);
        tick();
        chk("v_resp_clr", ch_resp, 2'b00);
        chk("v_rdata_clr", ch_rdata, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int got[$];

        vecs[0] = '{0, 1'b0, 16'h1236, 16'h0000, 2'b00,
                    128'hFFFF_EEEE_DDDD_CCCC_ABCD_2222_1111_0000,
                    0, 12'h123, 16'h00C0, 16'hABCD};
        vecs[1] = '{1, 1'b1, 16'h0042, 16'h5A00, 2'b10,
                    128'h0, 0, 12'h004, 16'h0008, 16'h0000};
        vecs[2] = '{0, 1'b0, 16'hFFFE, 16'h0000, 2'b01,
                    128'h1357_0000_0000_0000_0000_0000_0000_9999,
                    5, 12'hFFF, 16'hC000, 16'h1357};
        vecs[3] = '{1, 1'b0, 16'h0000, 16'h0000, 2'b00,
                    128'h1111_2222_3333_4444_5555_6666_7777_BEAD,
                    1, 12'h000, 16'h0003, 16'hBEAD};
        vecs[4] = '{0, 1'b1, 16'h0108, 16'hBEEF, 2'b11,
                    128'h0, 2, 12'h010, 16'h0300, 16'h0000};
        vecs[5] = '{1, 1'b1, 16'h000E, 16'h00C3, 2'b01,
                    128'h0, 1, 12'h000, 16'h4000, 16'h0000};
        vecs[6] = '{0, 1'b0, 16'h1237, 16'h0000, 2'b00,
                    128'h0000_0000_0000_0000_7777_0000_0000_0000,
                    0, 12'h123, 16'h00C0, 16'h7777};

        idle_inputs();
        @(posedge clk);
        #1;
        chk("rst_stb", wbi.wb_stb, 1'b0);
        chk("rst_cyc", wbi.wb_cyc, 1'b0);
        chk("rst_we", wbi.wb_we, 1'b0);
        chk("rst_adr", wbi.wb_adr, 12'h0);
        chk("rst_sel", wbi.wb_sel, 16'h0);
        chk("rst_dat_m", wbi.wb_dat_m, 128'h0);
        chk("rst_resp", ch_resp, 2'b00);
        chk("rst_rdata", ch_rdata, 16'h0);
        chk("rst_err", ch_err, 1'b0);
        do_reset();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Empty-byte-enable write: response in cycle 1, no bus cycle.
        ch_req = 2'b01;
        ch_we = 2'b01;
        ch_addr = 32'h0000_0020;
        ch_ben = 4'b0000;
        tick();
        chk("ben0_stb", wbi.wb_stb, 1'b0);
        chk("ben0_resp", ch_resp, 2'b01);
        chk("ben0_err", ch_err, 1'b0);
        ch_req = '0;
        ch_we = '0;
        tick();
        chk("ben0_resp_clr", ch_resp, 2'b00);

        // Ack while idle must be ignored.
        wbi.wb_ack = 1'b1;
        repeat (3) tick();
        chk("idle_ack_resp", ch_resp, 2'b00);
        chk("idle_ack_stb", wbi.wb_stb, 1'b0);
        wbi.wb_ack = 1'b0;

        // Request dropped after grant still completes.
        ch_req = 2'b10;
        ch_addr = 32'h0004_0000;
        tick();
        ch_req = '0;
        chk("drop_stb", wbi.wb_stb, 1'b1);
        tick();
        chk("drop_stb2", wbi.wb_stb, 1'b1);
        wbi.wb_dat_s = 128'h0000_0000_0000_0000_0000_0000_0000_4321_0000;
        wbi.wb_ack = 1'b1;
        tick();
        wbi.wb_ack = 1'b0;
        chk("drop_resp", ch_resp, 2'b10);
        chk("drop_rdata", ch_rdata, 16'h0000);
        tick();

`ifdef WB_ARB_RETRY_EN
        ch_req = 2'b01;
        ch_addr = 32'h0000_0010;
        wbi.wb_dat_s = {8{16'hDEAD}};
        tick();
        chk("rty_stb0", wbi.wb_stb, 1'b1);
        wbi.wb_rty = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("rty_gap_stb", wbi.wb_stb, 1'b0);
            chk("rty_gap_resp", ch_resp, 2'b00);
            tick();
            chk("rty_reissue_stb", wbi.wb_stb, 1'b1);
            chk("rty_reissue_adr", wbi.wb_adr, 12'h001);
        end
        tick();
        wbi.wb_rty = 1'b0;
        ch_req = '0;
        chk("rty_resp", ch_resp, 2'b01);
        chk("rty_err", ch_err, 1'b1);
        chk("rty_rdata", ch_rdata, 16'h0);
        chk("rty_stb_drop", wbi.wb_stb, 1'b0);
        tick();
        chk("rty_err_clr", ch_err, 1'b0);
`else
        ch_req = 2'b01;
        ch_addr = 32'h0000_0010;
        tick();
        wbi.wb_rty = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("rty_ign_stb", wbi.wb_stb, 1'b1);
            chk("rty_ign_resp", ch_resp, 2'b00);
        end
        wbi.wb_rty = 1'b0;
        wbi.wb_dat_s = {8{16'h2468}};
        wbi.wb_ack = 1'b1;
        tick();
        wbi.wb_ack = 1'b0;
        ch_req = '0;
        chk("rty_ign_resp_end", ch_resp, 2'b01);
        chk("rty_ign_err", ch_err, 1'b0);
        chk("rty_ign_rdata", ch_rdata, 16'h2468);
        tick();
`endif

        // Leave rr pointing at ch1, then reset in the middle of a transfer.
        ch_req = 2'b01;
        ch_addr = 32'h0000_0030;
        tick();
        chk("mid_stb", wbi.wb_stb, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", wbi.wb_stb, 1'b0);
        chk("mid_rst_cyc", wbi.wb_cyc, 1'b0);
        chk("mid_rst_resp", ch_resp, 2'b00);
        ch_req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wbi.wb_ack = 1'b1;
        tick();
        chk("post_rst_resp", ch_resp, 2'b00);
        wbi.wb_ack = 1'b0;

        // Both channels saturating: grants must alternate starting at ch0.
        ch_req = 2'b11;
        ch_we = 2'b00;
        ch_addr = 32'h0100_0200;
        wbi.wb_dat_s = '0;
        for (int c = 0; c < 200 && got.size() < 16; c++) begin
            tick();
            if (ch_resp[0]) got.push_back(0);
            if (ch_resp[1]) got.push_back(1);
            wbi.wb_ack = wbi.wb_stb;
        end
        ch_req = '0;
        wbi.wb_ack = 1'b0;
        chk("rr_count", 128'(got.size()), 128'd16);
        for (int i = 0; i < got.size(); i++)
            chk("rr_order", 128'(got[i]), 128'(i % 2));
        repeat (2) tick();
        chk("rr_idle_stb", wbi.wb_stb, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
